// File: rtl/avr_uart_fifo.sv
// UART link to the AVR companion chip: cclk-qualified enable, TX/RX FIFOs,
// and fixed-format serial engines.
module avr_uart_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop, do_push;

  // A push into a full buffer still lands when the head leaves in the same cycle.
  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level < (AW+1)'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// state    | meaning (shared by TX and RX engines)
// S_IDLE   | line idle / waiting for work or a start edge
// S_START  | start bit
// S_DATA   | data bits, LSB first
// S_PARITY | optional parity bit
// S_STOP   | stop bit
module avr_uart_fifo #(
  parameter int CLK_RATE          = 50000000,
  parameter int SERIAL_BAUD_RATE  = 500000,
  parameter int DATA_BITS         = 8,
  parameter int PARITY            = 0,
  parameter int FIFO_DEPTH        = 16,
  parameter int CCLK_READY_CYCLES = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cclk,
  input  logic                        rx,
  output logic                        tx,
  output logic                        ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_busy,
  output logic [7:0]                  rx_data,
  output logic                        rx_parity_err,
  output logic                        rx_frame_err,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level
);
  localparam int CPB_RAW     = (CLK_RATE + SERIAL_BAUD_RATE - 1) / SERIAL_BAUD_RATE;
  localparam int CLK_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
  localparam int CW          = $clog2(CLK_PER_BIT);
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;
  localparam int RW          = $clog2(CCLK_READY_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [RW-1:0] cclk_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         cclk_cnt <= '0;
    else if (!cclk)                                  cclk_cnt <= '0;
    else if (cclk_cnt != RW'(CCLK_READY_CYCLES))     cclk_cnt <= cclk_cnt + 1'b1;
  end

  assign ready = (cclk_cnt == RW'(CCLK_READY_CYCLES));

  state_t                tx_state, tx_next;
  logic                  tx_pop, tx_tick, tx_par, tx_bit;
  logic [CW-1:0]         tx_cnt;
  logic [2:0]            tx_idx;
  logic [DATA_BITS-1:0]  tx_sh, tx_head;

  assign tx_ready = ready && (tx_level < LW'(FIFO_DEPTH));
  assign tx_tick  = (tx_cnt == '0);
  assign tx_busy  = (tx_level != '0) || (tx_state != S_IDLE);

  avr_uart_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(!ready), .push(tx_valid && tx_ready), .pop(tx_pop),
    .din(tx_data[DATA_BITS-1:0]), .head(tx_head), .level(tx_level)
  );

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      S_IDLE:   if (tx_level != '0) begin tx_pop = 1'b1; tx_next = S_START; end
      S_START:  if (tx_tick) tx_next = S_DATA;
      S_DATA:   if (tx_tick && tx_idx == 3'(DATA_BITS - 1)) tx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_next = S_STOP;
      S_STOP: begin
        if (tx_tick) begin
          if (tx_level != '0) begin tx_pop = 1'b1; tx_next = S_START; end
          else                tx_next = S_IDLE;
        end
      end
      default:  tx_next = S_IDLE;
    endcase
    if (!ready) begin
      tx_next = S_IDLE;
      tx_pop  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else if (tx_pop) begin
      tx_sh  <= tx_head;
      tx_par <= (PARITY == 1) ? ~^tx_head : ^tx_head;
      tx_cnt <= CW'(CLK_PER_BIT - 1);
      tx_idx <= '0;
    end else if (tx_state != S_IDLE) begin
      if (tx_tick) begin
        tx_cnt <= CW'(CLK_PER_BIT - 1);
        if (tx_state == S_DATA) begin
          tx_sh  <= tx_sh >> 1;
          tx_idx <= tx_idx + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    tx_bit = 1'b1;
    case (tx_state)
      S_START:  tx_bit = 1'b0;
      S_DATA:   tx_bit = tx_sh[0];
      S_PARITY: tx_bit = tx_par;
      default:  tx_bit = 1'b1;
    endcase
  end

  assign tx = ready ? tx_bit : 1'bz;

  state_t                 rx_state, rx_next;
  logic [1:0]             rx_sync;
  logic                   rx_s, rx_prev, rx_tick, rx_push, rx_pop, rx_perr;
  logic [CW-1:0]          rx_cnt;
  logic [2:0]             rx_idx;
  logic [DATA_BITS-1:0]   rx_sh;
  logic [DATA_BITS+1:0]   rx_head;

  assign rx_s    = rx_sync[1];
  assign rx_tick = (rx_cnt == '0);
  assign rx_pop  = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  // Edge detection on the synchronised line also enforces a return to 1 after a bad stop bit.
  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    case (rx_state)
      S_IDLE:   if (rx_prev && !rx_s) rx_next = S_START;
      S_START:  if (rx_tick) rx_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_idx == 3'(DATA_BITS - 1)) rx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_next = S_STOP;
      S_STOP:   if (rx_tick) begin rx_push = 1'b1; rx_next = S_IDLE; end
      default:  rx_next = S_IDLE;
    endcase
    if (!ready) begin
      rx_next = S_IDLE;
      rx_push = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_perr <= 1'b0;
    end else if (rx_state == S_IDLE) begin
      rx_cnt  <= CW'(CLK_PER_BIT / 2 - 1);
      rx_idx  <= '0;
      rx_perr <= 1'b0;
    end else if (rx_tick) begin
      rx_cnt <= CW'(CLK_PER_BIT - 1);
      if (rx_state == S_DATA) begin
        rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
        rx_idx <= rx_idx + 1'b1;
      end
      if (rx_state == S_PARITY)
        rx_perr <= rx_s != ((PARITY == 1) ? ~^rx_sh : ^rx_sh);
    end else begin
      rx_cnt <= rx_cnt - 1'b1;
    end
  end

  avr_uart_fifo_buf #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(!ready), .push(rx_push), .pop(rx_pop),
    .din({!rx_s, rx_perr, rx_sh}), .head(rx_head), .level(rx_level)
  );

  assign rx_valid      = (rx_level != '0);
  assign rx_data       = rx_valid ? 8'(rx_head[DATA_BITS-1:0]) : 8'h00;
  assign rx_parity_err = rx_valid && rx_head[DATA_BITS];
  assign rx_frame_err  = rx_valid && rx_head[DATA_BITS+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_overrun <= 1'b0;
    else     rx_overrun <= rx_push && (rx_level == LW'(FIFO_DEPTH)) && !rx_pop;
  end
endmodule

// File: tb/tb_avr_uart_fifo.sv
// Directed bench for avr_uart_fifo: 4 clocks per bit, even parity, 4-deep FIFOs.
module tb_avr_uart_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cclk = 1'b0;
  logic       rx = 1'b1;
  wire        tx;
  logic       ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overrun;
  logic [2:0] tx_level, rx_level;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;

  avr_uart_fifo #(
    .CLK_RATE(40), .SERIAL_BAUD_RATE(10), .DATA_BITS(8), .PARITY(2),
    .FIFO_DEPTH(4), .CCLK_READY_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .cclk(cclk), .rx(rx), .tx(tx), .ready(ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .tx_level(tx_level), .rx_level(rx_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] frame_vec(input logic [7:0] d);
    logic [10:0] bits;
    bits = {1'b1, ^d, d, 1'b0};
    for (int j = 0; j < 44; j++) frame_vec[j] = bits[j / 4];
  endfunction

  task automatic send_rx(input logic [7:0] d, input logic par, input logic stp);
    rx = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (4) step();
    end
    rx = par;
    repeat (4) step();
    rx = stp;
    repeat (4) step();
    rx = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({ready, tx_ready, tx_busy, rx_valid, rx_parity_err, rx_frame_err, rx_overrun} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {ready, tx_ready, tx_busy, rx_valid, rx_parity_err, rx_frame_err, rx_overrun});
    end
    n_checks++;
    if ({rx_data, tx_level, rx_level} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_data_levels: rx_data=%h tx_level=%0d rx_level=%0d expected 0", rx_data, tx_level, rx_level);
    end
  endtask

  task automatic test_ready();
    rst = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      cclk = (i == 5) ? 1'b0 : 1'b1;
      step();
      if (i == 4 || i == 5 || i == 12 || i == 13) begin
        n_checks++;
        if (ready !== (i == 13)) begin
          n_fail++;
          $display("FAIL ready_glitch_edge%0d: got %b expected %b", i, ready, (i == 13));
        end
      end
    end
  endtask

  task automatic test_tx_frame();
    logic [43:0] vec, exp;
    logic [10:0] bits;
    bits = 11'b10101001010;
    for (int j = 0; j < 44; j++) exp[j] = bits[j / 4];
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n_checks++;
    if (tx !== 1'b1 || tx_level !== 3'd1) begin
      n_fail++;
      $display("FAIL tx_push_cycle: tx=%b level=%0d expected tx=1 level=1", tx, tx_level);
    end
    for (int j = 0; j < 44; j++) begin
      step();
      vec[j] = tx;
    end
    n_checks++;
    if (vec !== exp) begin
      n_fail++;
      $display("FAIL tx_frame_a5: got %b expected %b", vec, exp);
    end
    step();
    n_checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_idle_after: busy=%b tx=%b expected busy=0 tx=1", tx_busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3};
    fork
      begin
        int  acc;
        bit  chk, pre;
        acc = 0;
        chk = 0;
        for (int cyc = 0; cyc < 300 && acc < 6; cyc++) begin
          tx_data  = bytes[acc];
          tx_valid = 1'b1;
          if (acc == 5 && !chk) begin
            chk = 1;
            n_checks++;
            if (tx_ready !== 1'b0 || tx_level !== 3'd4 || cyc != 5) begin
              n_fail++;
              $display("FAIL b2b_full: tx_ready=%b level=%0d cycle=%0d expected 0/4/5", tx_ready, tx_level, cyc);
            end
          end
          pre = tx_ready;
          step();
          if (pre) acc++;
        end
        tx_valid = 1'b0;
        n_checks++;
        if (acc != 6) begin
          n_fail++;
          $display("FAIL b2b_accept_count: got %0d expected 6", acc);
        end
      end
      begin
        logic [43:0] vec;
        bit found;
        found = 0;
        for (int w = 0; w < 20 && !found; w++) begin
          step();
          if (tx === 1'b0) found = 1;
        end
        n_checks++;
        if (!found) begin
          n_fail++;
          $display("FAIL b2b_start_timeout: got no start bit expected one within 20 cycles");
        end else begin
          for (int f = 0; f < 6; f++) begin
            for (int j = 0; j < 44; j++) begin
              if (f != 0 || j != 0) step();
              vec[j] = tx;
            end
            n_checks++;
            if (vec !== frame_vec(bytes[f])) begin
              n_fail++;
              $display("FAIL b2b_frame%0d: got %b expected %b", f, vec, frame_vec(bytes[f]));
            end
          end
          step();
          n_checks++;
          if (tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_end: got %b expected 0", tx_busy);
          end
        end
      end
    join
  endtask

  task automatic test_rx_flags();
    int ovr0;
    ovr0 = ovr_cnt;
    rx_ready = 1'b0;
    send_rx(8'h3C, 1'b0, 1'b1);
    send_rx(8'h3C, 1'b1, 1'b1);
    send_rx(8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (rx_level !== 3'd3) begin
      n_fail++;
      $display("FAIL rx_flags_level: got %0d expected 3", rx_level);
    end
    n_checks++;
    if ({rx_frame_err, rx_parity_err, rx_data} !== {2'b00, 8'h3C}) begin
      n_fail++;
      $display("FAIL rx_good: got %b_%b_%h expected 0_0_3c", rx_frame_err, rx_parity_err, rx_data);
    end
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    n_checks++;
    if ({rx_frame_err, rx_parity_err, rx_data} !== {2'b01, 8'h3C}) begin
      n_fail++;
      $display("FAIL rx_parity: got %b_%b_%h expected 0_1_3c", rx_frame_err, rx_parity_err, rx_data);
    end
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    n_checks++;
    if ({rx_frame_err, rx_parity_err, rx_data} !== {2'b10, 8'h3C}) begin
      n_fail++;
      $display("FAIL rx_frame: got %b_%b_%h expected 1_0_3c", rx_frame_err, rx_parity_err, rx_data);
    end
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    n_checks++;
    if ({rx_valid, rx_data, rx_level} !== 12'h0 || ovr_cnt != ovr0) begin
      n_fail++;
      $display("FAIL rx_drained: valid=%b data=%h level=%0d overruns=%0d expected 0/00/0/0",
               rx_valid, rx_data, rx_level, ovr_cnt - ovr0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [5];
    int ovr0;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ovr0 = ovr_cnt;
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rx(bytes[i], ^bytes[i], 1'b1);
    n_checks++;
    if (rx_level !== 3'd4 || ovr_cnt - ovr0 != 1 || rx_data !== 8'h11) begin
      n_fail++;
      $display("FAIL overrun: level=%0d pulses=%0d head=%h expected 4/1/11", rx_level, ovr_cnt - ovr0, rx_data);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_data !== bytes[i]) begin
        n_fail++;
        $display("FAIL overrun_order%0d: got %h expected %h", i, rx_data, bytes[i]);
      end
      step();
    end
    rx_ready = 1'b0;
    n_checks++;
    if (rx_level !== 3'd0) begin
      n_fail++;
      $display("FAIL overrun_drain: got %0d expected 0", rx_level);
    end
  endtask

  task automatic test_glitch();
    int ovr0;
    ovr0 = ovr_cnt;
    rx = 1'b0;
    step();
    rx = 1'b1;
    repeat (20) step();
    n_checks++;
    if (rx_level !== 3'd0 || rx_valid !== 1'b0 || ovr_cnt != ovr0) begin
      n_fail++;
      $display("FAIL glitch_reject: level=%0d valid=%b overruns=%0d expected 0/0/0", rx_level, rx_valid, ovr_cnt - ovr0);
    end
    send_rx(8'h96, ^8'h96, 1'b1);
    n_checks++;
    if ({rx_level, rx_frame_err, rx_parity_err, rx_data} !== {3'd1, 2'b00, 8'h96}) begin
      n_fail++;
      $display("FAIL glitch_recover: level=%0d flags=%b%b data=%h expected 1/00/96",
               rx_level, rx_frame_err, rx_parity_err, rx_data);
    end
  endtask

  task automatic test_ready_drop();
    tx_valid = 1'b1; tx_data = 8'h12; step();
    tx_data = 8'h34; step();
    tx_valid = 1'b0;
    n_checks++;
    if ({tx_level, rx_level} !== {3'd1, 3'd1}) begin
      n_fail++;
      $display("FAIL drop_pre_levels: tx=%0d rx=%0d expected 1/1", tx_level, rx_level);
    end
    cclk = 1'b0;
    step();
    n_checks++;
    if ({ready, tx_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_ready: ready=%b tx_ready=%b expected 0/0", ready, tx_ready);
    end
    cclk = 1'b1;
    step();
    n_checks++;
    if ({tx_level, rx_level, tx_busy, rx_valid} !== 8'h0) begin
      n_fail++;
      $display("FAIL drop_flush: tx=%0d rx=%0d busy=%b valid=%b expected 0/0/0/0", tx_level, rx_level, tx_busy, rx_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit up;
    up = 0;
    for (int w = 0; w < 20 && !up; w++) begin
      step();
      up = ready;
    end
    n_checks++;
    if (!up) begin
      n_fail++;
      $display("FAIL mid_ready_timeout: got ready=0 expected 1 within 20 cycles");
    end
    tx_data = 8'h55; tx_valid = 1'b1; step(); tx_valid = 1'b0;
    rx = 1'b0;
    repeat (12) step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ready, tx_ready, tx_busy, rx_valid, tx_level, rx_level} !== 10'h0) begin
      n_fail++;
      $display("FAIL mid_async_reset: ready=%b tx_ready=%b busy=%b valid=%b tx=%0d rx=%0d expected all 0",
               ready, tx_ready, tx_busy, rx_valid, tx_level, rx_level);
    end
    rx = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i >= 7) begin
        n_checks++;
        if (ready !== (i == 8)) begin
          n_fail++;
          $display("FAIL mid_ready_edge%0d: got %b expected %b", i, ready, (i == 8));
        end
      end
    end
    repeat (40) step();
    n_checks++;
    if ({rx_level, tx_busy} !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_no_partial: rx_level=%0d busy=%b expected 0/0", rx_level, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_ready();
    test_tx_frame();
    test_back_to_back();
    test_rx_flags();
    test_overrun();
    test_glitch();
    test_ready_drop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/avr_uart_fifo.md
AVR_UART_FIFO -- requirements
Module: avr_uart_fifo

Interface
REQ-001 Parameter CLK_RATE, default 50000000, meaning clk frequency in Hz.
REQ-002 Parameter SERIAL_BAUD_RATE, default 500000, meaning line bit rate.
REQ-003 Parameter DATA_BITS, default 8, meaning frame data width; legal values are 5..8.
REQ-004 Parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter FIFO_DEPTH, default 16, meaning entries per FIFO; legal values are powers of two from 2 to 64.
REQ-006 Parameter CCLK_READY_CYCLES, default 512, meaning the number of consecutive cclk-high cycles required before ready.
REQ-007 Derived value CLK_PER_BIT SHALL equal ceil(CLK_RATE/SERIAL_BAUD_RATE), and SHALL be at least 4.
REQ-008 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cclk  in  1  AVR configuration clock; high means the AVR is ready.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output, tri-stated when not ready.
- ready  out  1  link enabled.
- tx_data  in  8  byte to send; bits above DATA_BITS-1 are ignored.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  TX FIFO can accept.
- tx_busy  out  1  TX FIFO non-empty or a frame is in flight.
- rx_data  out  8  head-of-RX-FIFO byte; bits above DATA_BITS-1 read 0.
- rx_parity_err  out  1  head entry had a parity error.
- rx_frame_err  out  1  head entry had a bad stop bit.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  consumer pops the head entry.
- rx_overrun  out  1  one-cycle pulse when a received frame is dropped.
- tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-009 The block SHALL count consecutive cclk-high cycles and assert ready once the count reaches CCLK_READY_CYCLES.
REQ-010 Any cclk-low cycle SHALL clear the count and deassert ready in the next cycle.
REQ-011 While ready is low: tx SHALL be Z, both FIFOs SHALL be flushed, both engines SHALL be held in IDLE, tx_ready SHALL be 0, and no rx_overrun SHALL pulse.
REQ-012 A TX push SHALL occur exactly when tx_valid && tx_ready; tx_ready SHALL equal ready && (tx_level < FIFO_DEPTH).
REQ-013 The TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and each of START, DATA bits, PARITY and STOP SHALL last CLK_PER_BIT cycles.
REQ-014 TX transitions:
- IDLE -> START when the FIFO is non-empty, popping one entry.
- START -> DATA.
- DATA -> PARITY after DATA_BITS bits if PARITY != 0, else DATA -> STOP.
- PARITY -> STOP.
- STOP -> START if the FIFO is non-empty (back-to-back frames, no idle gap), else STOP -> IDLE.
REQ-015 Frames SHALL be sent as: start bit 0, data LSB first, optional parity bit, then one stop bit 1; the line SHALL be 1 in IDLE.
REQ-016 For a push into an empty TX FIFO while IDLE at cycle N, tx SHALL first drive 0 at cycle N+2.
REQ-017 rx SHALL pass through a 2-flop synchroniser; all RX timing SHALL be relative to the synchronised signal.
REQ-018 The RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and IDLE -> START SHALL occur on a synchronised 1->0 transition.
REQ-019 In START, the line SHALL be sampled CLK_PER_BIT/2 cycles after the edge; if it is 1 the FSM SHALL return to IDLE with no push.
REQ-020 Every subsequent bit SHALL be sampled CLK_PER_BIT cycles after the previous sample.
REQ-021 Parity error SHALL be set when PARITY != 0 and the received parity bit mismatches the configured mode; frame error SHALL be set when the stop sample is 0.
REQ-022 On the stop sample, {frame_err, parity_err, data} SHALL be pushed as one entry; errored frames SHALL still be stored.
REQ-023 After a 0 stop sample, the RX FSM SHALL wait for the line to return to 1 before leaving IDLE.
REQ-024 An RX push SHALL succeed if rx_level < FIFO_DEPTH or a pop occurs in the same cycle; otherwise the entry SHALL be discarded and rx_overrun SHALL pulse for 1 cycle.
REQ-025 The RX FIFO SHALL be show-ahead: rx_data and the error flags SHALL reflect the head whenever rx_valid is 1, and a pop SHALL occur on rx_valid && rx_ready.
REQ-026 A simultaneous push and pop SHALL leave the level unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 A pop on an empty FIFO or a push on a full FIFO SHALL leave the level and pointers unchanged.

Reset
REQ-028 With rst high, asynchronously: ready=0, tx=Z, tx_ready=0, tx_busy=0, rx_valid=0, rx_data=0, both error flags=0, rx_overrun=0, both levels=0, both FSMs in IDLE, cclk count=0, synchroniser flops=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no partial push; after release, the block SHALL require a full CCLK_READY_CYCLES of cclk high before ready.

Verification
REQ-030 Hold cclk=1 with CCLK_READY_CYCLES=8 -> ready=1 after 8 cycles; a one-cycle cclk=0 glitch at cycle 5 -> ready stays 0 until 8 further high cycles.
REQ-031 With CLK_PER_BIT=4, DATA_BITS=8, PARITY=2, push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles wide, first 0 at push+2.
REQ-032 With FIFO_DEPTH=4, push 6 bytes back-to-back -> tx_ready drops after 5 accepted (one popped to the engine), frames are contiguous, and tx_busy falls after the last stop bit.
REQ-033 Drive RX frames 0x3C (good), 0x3C with odd parity under PARITY=2, and 0x3C with stop=0 -> three entries with flags (0,0), (parity=1), (frame=1).
REQ-034 Hold rx_ready=0 and receive FIFO_DEPTH+1 frames -> rx_level=FIFO_DEPTH, one rx_overrun pulse, and the head still holds the first byte.
REQ-035 Drive a 1-cycle rx low pulse -> START rejects it, with no push and no error.
